// File: rtl/user_pkg.sv
// User-domain address map, subordinate indices and error-response data shared by the
// user-domain demux and its error subordinate.
package user_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  typedef enum logic [1:0] {
    UserError      = 2'd0,
    UserRom        = 2'd1,
    UserRedisCache = 2'd2
  } user_demux_outputs_e;

  localparam int unsigned NumUserDomainSubordinates = 2;

  localparam logic [31:0] UserRomAddrOffset        = 32'h2000_0000;
  localparam logic [31:0] UserRomAddrRange         = 32'h0000_1000;
  localparam logic [31:0] UserRedisCacheAddrOffset = 32'h2000_1000;
  localparam logic [31:0] UserRedisCacheAddrRange  = 32'h0000_1000;

  // End addresses are exclusive.
  localparam addr_map_rule_t [NumUserDomainSubordinates-1:0] user_addr_map = '{
    '{idx:        32'(UserRedisCache),
      start_addr: UserRedisCacheAddrOffset,
      end_addr:   UserRedisCacheAddrOffset + UserRedisCacheAddrRange},
    '{idx:        32'(UserRom),
      start_addr: UserRomAddrOffset,
      end_addr:   UserRomAddrOffset + UserRomAddrRange}
  };

  localparam logic [31:0] ErrData = 32'hBADCAB1E;

endpackage

// File: rtl/user_obi_err_sbr.sv
// OBI error subordinate: always grants and answers every accepted request one cycle
// later with err set and a fixed read-data pattern.
module user_obi_err_sbr
  import user_pkg::*;
#(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          IdWidth   = 1,
  parameter logic [DataWidth-1:0] RespData  = DataWidth'(ErrData)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [IdWidth-1:0]   aid_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  output logic [IdWidth-1:0]   rid_o
);

  logic               rvalid_q;
  logic [IdWidth-1:0] rid_q;

  assign gnt_o = 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= req_i;
      if (req_i) begin
        rid_q <= aid_i;
      end
    end
  end

  // Idle response fields are forced to zero so the manager side stays quiet.
  assign rvalid_o = rvalid_q;
  assign err_o    = rvalid_q;
  assign rdata_o  = rvalid_q ? RespData : '0;
  assign rid_o    = rvalid_q ? rid_q : '0;

endmodule

// File: rtl/user_obi_demux.sv
// OBI 1-to-N demux for the user domain: rule-table decode, in-order response return via a
// single-target outstanding counter, and an internal error subordinate on port 0.
module user_obi_demux
  import user_pkg::addr_map_rule_t;
  import user_pkg::user_addr_map;
#(
  parameter int unsigned                    AddrWidth = 32,
  parameter int unsigned                    DataWidth = 32,
  parameter int unsigned                    IdWidth   = 1,
  parameter int unsigned                    NumRules  = 2,
  parameter addr_map_rule_t [NumRules-1:0]  AddrMap   = user_addr_map,
  parameter int unsigned                    MaxTrans  = 4,
  parameter logic [DataWidth-1:0]           ErrData   = DataWidth'(user_pkg::ErrData)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,

  input  logic                          mgr_req_i,
  output logic                          mgr_gnt_o,
  input  logic [AddrWidth-1:0]          mgr_addr_i,
  input  logic                          mgr_we_i,
  input  logic [DataWidth/8-1:0]        mgr_be_i,
  input  logic [DataWidth-1:0]          mgr_wdata_i,
  input  logic [IdWidth-1:0]            mgr_aid_i,
  output logic                          mgr_rvalid_o,
  output logic [DataWidth-1:0]          mgr_rdata_o,
  output logic                          mgr_err_o,
  output logic [IdWidth-1:0]            mgr_rid_o,

  output logic [NumRules-1:0]           sbr_req_o,
  input  logic [NumRules-1:0]           sbr_gnt_i,
  output logic [AddrWidth-1:0]          sbr_addr_o,
  output logic                          sbr_we_o,
  output logic [DataWidth/8-1:0]        sbr_be_o,
  output logic [DataWidth-1:0]          sbr_wdata_o,
  output logic [IdWidth-1:0]            sbr_aid_o,
  input  logic [NumRules-1:0]           sbr_rvalid_i,
  input  logic [NumRules*DataWidth-1:0] sbr_rdata_i,
  input  logic [NumRules-1:0]           sbr_err_i,
  input  logic [NumRules*IdWidth-1:0]   sbr_rid_i
);

  localparam int unsigned NumPorts = NumRules + 1;
  localparam int unsigned SelWidth = $clog2(NumPorts);
  localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

  logic [SelWidth-1:0]  sel, last_sel_q;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 stall, accept;

  logic                 err_req, err_gnt, err_rvalid, err_err;
  logic [DataWidth-1:0] err_rdata;
  logic [IdWidth-1:0]   err_rid;

  logic                 resp_rvalid, resp_err;
  logic [DataWidth-1:0] resp_rdata;
  logic [IdWidth-1:0]   resp_rid;

  // Walk rules from highest to lowest index so the lowest matching rule wins.
  always_comb begin
    sel = '0;
    for (int r = int'(NumRules) - 1; r >= 0; r--) begin
      if (mgr_addr_i >= AddrWidth'(AddrMap[r].start_addr) &&
          mgr_addr_i <  AddrWidth'(AddrMap[r].end_addr)) begin
        sel = SelWidth'(AddrMap[r].idx);
      end
    end
  end

  assign stall = (cnt_q == CntWidth'(MaxTrans)) || ((cnt_q != '0) && (sel != last_sel_q));

  always_comb begin
    sbr_req_o = '0;
    err_req   = 1'b0;
    mgr_gnt_o = 1'b0;
    if (!stall) begin
      if (sel == '0) begin
        err_req   = mgr_req_i;
        mgr_gnt_o = mgr_req_i & err_gnt;
      end
      for (int k = 0; k < int'(NumRules); k++) begin
        if (sel == SelWidth'(k + 1)) begin
          sbr_req_o[k] = mgr_req_i;
          mgr_gnt_o    = mgr_req_i & sbr_gnt_i[k];
        end
      end
    end
  end

  assign accept = mgr_req_i & mgr_gnt_o;

  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_wdata_o = mgr_wdata_i;
  assign sbr_aid_o   = mgr_aid_i;

  always_comb begin
    resp_rvalid = err_rvalid;
    resp_err    = err_err;
    resp_rdata  = err_rdata;
    resp_rid    = err_rid;
    for (int k = 0; k < int'(NumRules); k++) begin
      if (last_sel_q == SelWidth'(k + 1)) begin
        resp_rvalid = sbr_rvalid_i[k];
        resp_err    = sbr_err_i[k];
        resp_rdata  = sbr_rdata_i[k*DataWidth +: DataWidth];
        resp_rid    = sbr_rid_i[k*IdWidth +: IdWidth];
      end
    end
  end

  // A response only counts while something is outstanding; stale rvalids are dropped.
  assign mgr_rvalid_o = resp_rvalid & (cnt_q != '0);
  assign mgr_err_o    = mgr_rvalid_o & resp_err;
  assign mgr_rdata_o  = mgr_rvalid_o ? resp_rdata : '0;
  assign mgr_rid_o    = mgr_rvalid_o ? resp_rid : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !mgr_rvalid_o && (cnt_q != CntWidth'(MaxTrans))) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (mgr_rvalid_o && !accept && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      last_sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        last_sel_q <= sel;
      end
    end
  end

  user_obi_err_sbr #(
    .DataWidth (DataWidth),
    .IdWidth   (IdWidth),
    .RespData  (ErrData)
  ) u_err_sbr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (err_req),
    .gnt_o    (err_gnt),
    .aid_i    (mgr_aid_i),
    .rvalid_o (err_rvalid),
    .rdata_o  (err_rdata),
    .err_o    (err_err),
    .rid_o    (err_rid)
  );

  for (genvar k = 0; k < NumRules; k++) begin : gen_rvalid_chk
    rvalid_from_unselected : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (sbr_rvalid_i[k] && (cnt_q != '0)) |-> (last_sel_q == SelWidth'(k + 1)));
  end

endmodule

// File: tb/tb_user_obi_demux.sv
// Directed bench for user_obi_demux: decode, error subordinate, outstanding limit,
// target switching, simultaneous accept/response and reset behaviour.
module tb_user_obi_demux;

  // Rule 0 (port 1) lies inside rule 1 (port 2) so decode priority is observable.
  localparam user_pkg::addr_map_rule_t [1:0] TbMap = '{
    '{idx: 32'd2, start_addr: 32'h2000_0000, end_addr: 32'h2000_2000},
    '{idx: 32'd1, start_addr: 32'h2000_0000, end_addr: 32'h2000_1000}
  };

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mgr_req = 1'b0, mgr_gnt, mgr_we = 1'b0;
  logic [31:0] mgr_addr = '0, mgr_wdata = '0, mgr_rdata;
  logic [3:0]  mgr_be = '0;
  logic        mgr_aid = 1'b0, mgr_rvalid, mgr_err, mgr_rid;
  logic [1:0]  sbr_req, sbr_gnt = 2'b11, sbr_rvalid = 2'b00, sbr_err = 2'b00, sbr_rid = 2'b00;
  logic [31:0] sbr_addr, sbr_wdata;
  logic        sbr_we, sbr_aid;
  logic [3:0]  sbr_be;
  logic [63:0] sbr_rdata = '0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  user_obi_demux #(
    .AddrWidth (32),
    .DataWidth (32),
    .IdWidth   (1),
    .NumRules  (2),
    .AddrMap   (TbMap),
    .MaxTrans  (4),
    .ErrData   (32'hBADCAB1E)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .mgr_req_i    (mgr_req),
    .mgr_gnt_o    (mgr_gnt),
    .mgr_addr_i   (mgr_addr),
    .mgr_we_i     (mgr_we),
    .mgr_be_i     (mgr_be),
    .mgr_wdata_i  (mgr_wdata),
    .mgr_aid_i    (mgr_aid),
    .mgr_rvalid_o (mgr_rvalid),
    .mgr_rdata_o  (mgr_rdata),
    .mgr_err_o    (mgr_err),
    .mgr_rid_o    (mgr_rid),
    .sbr_req_o    (sbr_req),
    .sbr_gnt_i    (sbr_gnt),
    .sbr_addr_o   (sbr_addr),
    .sbr_we_o     (sbr_we),
    .sbr_be_o     (sbr_be),
    .sbr_wdata_o  (sbr_wdata),
    .sbr_aid_o    (sbr_aid),
    .sbr_rvalid_i (sbr_rvalid),
    .sbr_rdata_i  (sbr_rdata),
    .sbr_err_i    (sbr_err),
    .sbr_rid_i    (sbr_rid)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests_run++; if (mgr_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt: got %b want 0", mgr_gnt); end
    tests_run++; if (sbr_req !== 2'b00) begin tests_failed++; $display("FAIL reset_req: got %b want 00", sbr_req); end
    tests_run++; if (dut.cnt_q !== 3'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q); end
    step();
    rst_ni = 1'b1;
    #1;
    tests_run++;
    if ({mgr_gnt, mgr_rvalid, mgr_err, mgr_rid, mgr_rdata} !== 36'd0) begin
      tests_failed++;
      $display("FAIL idle_outputs: got gnt=%b rv=%b err=%b rid=%b rdata=%h want all 0",
               mgr_gnt, mgr_rvalid, mgr_err, mgr_rid, mgr_rdata);
    end
  endtask

  task automatic test_read_port1();
    step();
    mgr_req = 1'b1; mgr_addr = 32'h2000_0004; mgr_we = 1'b0; mgr_aid = 1'b1; mgr_be = 4'hF;
    #1;
    tests_run++; if (sbr_req !== 2'b01) begin tests_failed++; $display("FAIL rd_req: got %b want 01", sbr_req); end
    tests_run++; if (mgr_gnt !== 1'b1) begin tests_failed++; $display("FAIL rd_gnt: got %b want 1", mgr_gnt); end
    tests_run++; if (sbr_addr !== 32'h2000_0004) begin tests_failed++; $display("FAIL rd_addr: got %h want 20000004", sbr_addr); end
    step();
    mgr_req = 1'b0; sbr_rvalid = 2'b01; sbr_rdata[31:0] = 32'h0000_1234; sbr_err = 2'b00; sbr_rid = 2'b01;
    #1;
    tests_run++; if (mgr_rvalid !== 1'b1) begin tests_failed++; $display("FAIL rd_rvalid: got %b want 1", mgr_rvalid); end
    tests_run++; if (mgr_rdata !== 32'h0000_1234) begin tests_failed++; $display("FAIL rd_rdata: got %h want 00001234", mgr_rdata); end
    tests_run++; if (mgr_err !== 1'b0) begin tests_failed++; $display("FAIL rd_err: got %b want 0", mgr_err); end
    tests_run++; if (mgr_rid !== 1'b1) begin tests_failed++; $display("FAIL rd_rid: got %b want 1", mgr_rid); end
    step();
    sbr_rvalid = 2'b00;
    #1;
    tests_run++; if (dut.cnt_q !== 3'd0) begin tests_failed++; $display("FAIL rd_cnt: got %0d want 0", dut.cnt_q); end
  endtask

  task automatic test_error();
    mgr_req = 1'b1; mgr_addr = 32'h3000_0000; mgr_we = 1'b1; mgr_aid = 1'b1; mgr_wdata = 32'h5555_AAAA;
    #1;
    tests_run++; if (mgr_gnt !== 1'b1) begin tests_failed++; $display("FAIL err_gnt: got %b want 1", mgr_gnt); end
    tests_run++; if (sbr_req !== 2'b00) begin tests_failed++; $display("FAIL err_noreq: got %b want 00", sbr_req); end
    step();
    mgr_req = 1'b0;
    #1;
    tests_run++; if (mgr_rvalid !== 1'b1) begin tests_failed++; $display("FAIL err_rvalid: got %b want 1", mgr_rvalid); end
    tests_run++; if (mgr_err !== 1'b1) begin tests_failed++; $display("FAIL err_err: got %b want 1", mgr_err); end
    tests_run++; if (mgr_rdata !== 32'hBADCAB1E) begin tests_failed++; $display("FAIL err_rdata: got %h want badcab1e", mgr_rdata); end
    tests_run++; if (mgr_rid !== 1'b1) begin tests_failed++; $display("FAIL err_rid: got %b want 1", mgr_rid); end
    step();
    tests_run++; if (mgr_rvalid !== 1'b0) begin tests_failed++; $display("FAIL err_single: got %b want 0", mgr_rvalid); end
    // Back-to-back error accesses with different ids.
    mgr_req = 1'b1; mgr_we = 1'b0; mgr_aid = 1'b0;
    step();
    mgr_aid = 1'b1;
    #1;
    tests_run++; if (mgr_gnt !== 1'b1) begin tests_failed++; $display("FAIL err_b2b_gnt: got %b want 1", mgr_gnt); end
    tests_run++; if ({mgr_rvalid, mgr_rid} !== 2'b10) begin tests_failed++; $display("FAIL err_b2b_rsp0: got rv/rid %b want 10", {mgr_rvalid, mgr_rid}); end
    step();
    mgr_req = 1'b0;
    #1;
    tests_run++; if ({mgr_rvalid, mgr_rid} !== 2'b11) begin tests_failed++; $display("FAIL err_b2b_rsp1: got rv/rid %b want 11", {mgr_rvalid, mgr_rid}); end
    step();
    tests_run++; if (dut.cnt_q !== 3'd0) begin tests_failed++; $display("FAIL err_cnt: got %0d want 0", dut.cnt_q); end
  endtask

  task automatic test_max_trans();
    mgr_req = 1'b1; mgr_addr = 32'h2000_1000; mgr_we = 1'b0; mgr_aid = 1'b0;
    sbr_rdata[63:32] = 32'hCAFE_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++; if ({mgr_gnt, sbr_req} !== 3'b110) begin tests_failed++; $display("FAIL max_grant%0d: got gnt/req %b want 110", i, {mgr_gnt, sbr_req}); end
      step();
    end
    tests_run++; if ({mgr_gnt, sbr_req} !== 3'b000) begin tests_failed++; $display("FAIL max_stall: got gnt/req %b want 000", {mgr_gnt, sbr_req}); end
    tests_run++; if (dut.cnt_q !== 3'd4) begin tests_failed++; $display("FAIL max_cnt: got %0d want 4", dut.cnt_q); end
    sbr_rvalid = 2'b10;
    #1;
    tests_run++; if (mgr_rdata !== 32'hCAFE_0002) begin tests_failed++; $display("FAIL max_rdata: got %h want cafe0002", mgr_rdata); end
    tests_run++; if (mgr_gnt !== 1'b0) begin tests_failed++; $display("FAIL max_same_cycle: got %b want 0", mgr_gnt); end
    step();
    sbr_rvalid = 2'b00;
    #1;
    tests_run++; if (mgr_gnt !== 1'b1) begin tests_failed++; $display("FAIL max_fifth: got %b want 1", mgr_gnt); end
    step();
    mgr_req = 1'b0;
    tests_run++; if (dut.cnt_q !== 3'd4) begin tests_failed++; $display("FAIL max_cnt_refill: got %0d want 4", dut.cnt_q); end
    sbr_rvalid = 2'b10;
    for (int i = 0; i < 4; i++) step();
    sbr_rvalid = 2'b00;
    tests_run++; if (dut.cnt_q !== 3'd0) begin tests_failed++; $display("FAIL max_drain: got %0d want 0", dut.cnt_q); end
  endtask

  task automatic test_target_switch();
    mgr_req = 1'b1; mgr_addr = 32'h2000_0004;
    step();
    mgr_addr = 32'h2000_1000;
    #1;
    tests_run++; if ({mgr_gnt, sbr_req} !== 3'b000) begin tests_failed++; $display("FAIL sw_stall: got gnt/req %b want 000", {mgr_gnt, sbr_req}); end
    step();
    tests_run++; if ({mgr_gnt, sbr_req} !== 3'b000) begin tests_failed++; $display("FAIL sw_stall2: got gnt/req %b want 000", {mgr_gnt, sbr_req}); end
    sbr_rvalid = 2'b01;
    #1;
    tests_run++; if ({mgr_rvalid, mgr_gnt} !== 2'b10) begin tests_failed++; $display("FAIL sw_last_rsp: got rv/gnt %b want 10", {mgr_rvalid, mgr_gnt}); end
    step();
    sbr_rvalid = 2'b00;
    #1;
    tests_run++; if ({mgr_gnt, sbr_req} !== 3'b110) begin tests_failed++; $display("FAIL sw_grant: got gnt/req %b want 110", {mgr_gnt, sbr_req}); end
    step();
    mgr_req = 1'b0; sbr_rvalid = 2'b10;
    step();
    sbr_rvalid = 2'b00;
    tests_run++; if (dut.cnt_q !== 3'd0) begin tests_failed++; $display("FAIL sw_cnt: got %0d want 0", dut.cnt_q); end
  endtask

  task automatic test_simultaneous();
    mgr_req = 1'b1; mgr_addr = 32'h2000_0008;
    step();
    step();
    sbr_rvalid = 2'b01;
    #1;
    tests_run++; if ({mgr_gnt, mgr_rvalid} !== 2'b11) begin tests_failed++; $display("FAIL sim_both: got gnt/rv %b want 11", {mgr_gnt, mgr_rvalid}); end
    step();
    mgr_req = 1'b0;
    tests_run++; if (dut.cnt_q !== 3'd2) begin tests_failed++; $display("FAIL sim_cnt: got %0d want 2", dut.cnt_q); end
    step();
    step();
    sbr_rvalid = 2'b00;
    tests_run++; if (dut.cnt_q !== 3'd0) begin tests_failed++; $display("FAIL sim_drain: got %0d want 0", dut.cnt_q); end
  endtask

  task automatic test_overlap();
    logic [31:0] addrs [4] = '{32'h2000_0FFC, 32'h2000_1000, 32'h1FFF_FFFC, 32'h2000_2000};
    logic [2:0]  exp   [4] = '{3'b101, 3'b110, 3'b100, 3'b100};
    mgr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mgr_addr = addrs[i];
      #1;
      tests_run++;
      if ({mgr_gnt, sbr_req} !== exp[i]) begin
        tests_failed++;
        $display("FAIL decode_%h: got gnt/req %b want %b", addrs[i], {mgr_gnt, sbr_req}, exp[i]);
      end
    end
    mgr_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    mgr_req = 1'b1; mgr_addr = 32'h2000_0010;
    for (int i = 0; i < 3; i++) step();
    mgr_req = 1'b0;
    tests_run++; if (dut.cnt_q !== 3'd3) begin tests_failed++; $display("FAIL rst_pre_cnt: got %0d want 3", dut.cnt_q); end
    rst_ni = 1'b0;
    #1;
    tests_run++; if (dut.cnt_q !== 3'd0) begin tests_failed++; $display("FAIL rst_cnt: got %0d want 0", dut.cnt_q); end
    tests_run++; if (dut.last_sel_q !== 2'd0) begin tests_failed++; $display("FAIL rst_last_sel: got %0d want 0", dut.last_sel_q); end
    step();
    rst_ni = 1'b1;
    sbr_rvalid = 2'b01;
    #1;
    tests_run++; if (mgr_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_stray: got %b want 0", mgr_rvalid); end
    step();
    sbr_rvalid = 2'b00;
    tests_run++; if (dut.cnt_q !== 3'd0) begin tests_failed++; $display("FAIL rst_post_cnt: got %0d want 0", dut.cnt_q); end
  endtask

  initial begin
    test_reset();
    test_read_port1();
    test_error();
    test_max_trans();
    test_target_switch();
    test_simultaneous();
    test_overlap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
